// File: rtl/probe_arb_pkg.sv
// Shared types and constants for the debug-probe arbiter.
// LED constants are packed {R,G,B}, active-low.
package probe_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam logic [2:0] LINK_SEL_NONE = 3'd0;

  localparam logic [2:0] LED_IDLE  = 3'b011;
  localparam logic [2:0] LED_OWNED = 3'b101;
  localparam logic [2:0] LED_GUARD = 3'b010;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/probe_arbiter_if.sv
// Bundle of probe-side inputs and target-side outputs of the arbiter.
// master = probe/connector side, slave = the arbiter itself.
interface probe_arbiter_if #(
  parameter int N_PROBES = 3
);

  logic [N_PROBES-1:0] probe_swclk;
  logic [N_PROBES-1:0] probe_reset;
  logic [N_PROBES-1:0] probe_tdi;
  logic [N_PROBES-1:0] probe_led_run;

  logic                debug_jtck_swclk;
  logic                debug_tdi;
  logic                debug_reset;
  logic [2:0]          link_sel;
  logic                owner_valid;
  logic                led_r;
  logic                led_g;
  logic                led_b;

  modport master (
    output probe_swclk, probe_reset, probe_tdi, probe_led_run,
    input  debug_jtck_swclk, debug_tdi, debug_reset, link_sel,
    input  owner_valid, led_r, led_g, led_b
  );

  modport slave (
    input  probe_swclk, probe_reset, probe_tdi, probe_led_run,
    output debug_jtck_swclk, debug_tdi, debug_reset, link_sel,
    output owner_valid, led_r, led_g, led_b
  );

endinterface

// File: rtl/probe_activity_det.sv
// Per-probe activity detector: synchronises SWCLK/nRESET and flags any change.
// With PROBE_ARB_CLAIM_FILTER_EN a claim needs CLAIM_EDGES closely spaced edges.
module probe_activity_det
  import probe_arb_pkg::*;
`ifdef PROBE_ARB_CLAIM_FILTER_EN
#(
  parameter int CLAIM_EDGES = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic swclk_async,
  input  logic reset_async,
`ifdef PROBE_ARB_CLAIM_FILTER_EN
  input  logic count_en,
`endif
  output logic edge_flag,
  output logic claim_req
);

  logic [1:0] sync_sw;
  logic [1:0] sync_rst;
  logic       prev_sw;
  logic       prev_rst;

  // Idle line level is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sw   <= 2'b11;
      sync_rst  <= 2'b11;
      prev_sw   <= 1'b1;
      prev_rst  <= 1'b1;
      edge_flag <= 1'b0;
    end else begin
      sync_sw   <= {sync_sw[0], swclk_async};
      sync_rst  <= {sync_rst[0], reset_async};
      prev_sw   <= sync_sw[1];
      prev_rst  <= sync_rst[1];
      edge_flag <= (sync_sw[1] ^ prev_sw) | (sync_rst[1] ^ prev_rst);
    end
  end

`ifdef PROBE_ARB_CLAIM_FILTER_EN
  localparam int EW = cnt_w(CLAIM_EDGES + 1);
  localparam logic [EW-1:0] EDGE_MAX  = EW'(CLAIM_EDGES);
  localparam logic [EW-1:0] EDGE_LAST = EW'(CLAIM_EDGES - 1);

  logic [EW-1:0] edge_cnt;
  logic [7:0]    gap_cnt;

  // A gap of more than 256 cycles between edges discards the partial count.
  always_ff @(posedge clk) begin
    if (rst || !count_en) begin
      edge_cnt <= '0;
      gap_cnt  <= '0;
    end else if (edge_flag) begin
      gap_cnt <= '0;
      if (edge_cnt != EDGE_MAX) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end else if (edge_cnt != '0) begin
      if (gap_cnt == 8'hFF) begin
        edge_cnt <= '0;
        gap_cnt  <= '0;
      end else begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  assign claim_req = edge_flag && (edge_cnt == EDGE_LAST);
`else
  assign claim_req = edge_flag;
`endif

endmodule

// File: rtl/probe_arbiter.sv
// Selects which debug probe drives the shared target port (ownership + idle timeout + guard).
// Optional claim filtering is enabled with `define PROBE_ARB_CLAIM_FILTER_EN.
module probe_arbiter
  import probe_arb_pkg::*;
#(
  parameter int N_PROBES     = 3,
  parameter int IDLE_CYCLES  = 1200000,
  parameter int GUARD_CYCLES = 1200,
  parameter int CLAIM_EDGES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  probe_arbiter_if.slave  bus
);

  localparam int OW = $clog2(N_PROBES);
  localparam int IW = cnt_w(IDLE_CYCLES);
  localparam int GW = cnt_w(GUARD_CYCLES);

  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_OWNED = ST_OWNED;
  localparam logic [1:0] S_GUARD = ST_GUARD;

  logic [1:0]          state;
  logic [OW-1:0]       owner;
  logic [IW-1:0]       idle_cnt;
  logic [GW-1:0]       guard_cnt;
  logic [2:0]          link_sel;

  logic [N_PROBES-1:0] edge_flag;
  logic [N_PROBES-1:0] claim_req;
  logic                claim_any;
  logic [OW-1:0]       claim_idx;

  logic                dbg_swclk;
  logic                dbg_tdi;
  logic                dbg_reset;
  logic                owner_valid;
  logic [2:0]          led_rgb;

`ifdef PROBE_ARB_CLAIM_FILTER_EN
  logic idle_now;
  assign idle_now = (state == S_IDLE);
`else
  localparam int unused_claim_edges = CLAIM_EDGES;
`endif

  for (genvar i = 0; i < N_PROBES; i++) begin : g_det
    probe_activity_det
`ifdef PROBE_ARB_CLAIM_FILTER_EN
      #(.CLAIM_EDGES(CLAIM_EDGES))
`endif
      u_det (
        .clk         (clk),
        .rst         (rst),
        .swclk_async (bus.probe_swclk[i]),
        .reset_async (bus.probe_reset[i]),
`ifdef PROBE_ARB_CLAIM_FILTER_EN
        .count_en    (idle_now),
`endif
        .edge_flag   (edge_flag[i]),
        .claim_req   (claim_req[i])
      );
  end

  // Lowest-numbered requester wins a simultaneous claim.
  always_comb begin
    claim_any = 1'b0;
    claim_idx = '0;
    for (int i = N_PROBES - 1; i >= 0; i--) begin
      if (claim_req[i]) begin
        claim_any = 1'b1;
        claim_idx = OW'(i);
      end
    end
  end

  // LINK_SEL is only written on a claim so the analog switch parks on the last probe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      idle_cnt  <= '0;
      guard_cnt <= '0;
      link_sel  <= LINK_SEL_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (claim_any) begin
            state    <= S_OWNED;
            owner    <= claim_idx;
            link_sel <= 3'(claim_idx) + 3'd1;
            idle_cnt <= '0;
          end
        end
        S_OWNED: begin
          if (edge_flag[owner]) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state     <= S_GUARD;
            idle_cnt  <= '0;
            guard_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state     <= S_IDLE;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // SWCLK/TDI/nRESET pass straight through from the owner with no register stage.
  always_comb begin
    dbg_swclk   = 1'b1;
    dbg_tdi     = 1'b1;
    dbg_reset   = 1'b1;
    owner_valid = 1'b0;
    led_rgb     = LED_IDLE;
    case (state)
      S_OWNED: begin
        dbg_swclk   = bus.probe_swclk[owner];
        dbg_tdi     = bus.probe_tdi[owner];
        dbg_reset   = bus.probe_reset[owner];
        owner_valid = 1'b1;
        led_rgb     = {LED_OWNED[2], bus.probe_led_run[owner], LED_OWNED[0]};
      end
      S_GUARD: begin
        led_rgb = LED_GUARD;
      end
      default: begin
        led_rgb = LED_IDLE;
      end
    endcase
  end

  assign bus.debug_jtck_swclk = dbg_swclk;
  assign bus.debug_tdi        = dbg_tdi;
  assign bus.debug_reset      = dbg_reset;
  assign bus.link_sel         = link_sel;
  assign bus.owner_valid      = owner_valid;
  assign bus.led_r            = led_rgb[2];
  assign bus.led_g            = led_rgb[1];
  assign bus.led_b            = led_rgb[0];

endmodule
